core_dbg_regs: RTL and testbench

Memory-interface responder holding the Core Debug register file. It sits on the slave side of the debug memory bus, driven by the JTAG Core Debug Port, and decodes each access into register reads and writes. It also runs the halt/resume/step handshake with the core and exports breakpoint configuration. Everything runs on a single clock, `memi_clk`.

---
 rtl/core_dbg_regs.sv | 151 +++++++++++++++
 tb/tb_core_dbg_regs.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dbg_regs.sv
// core_dbg_regs: debug memory-bus responder holding the Core Debug register file,
// the core halt/resume/step handshake and the breakpoint configuration.
module core_dbg_regs #(
    parameter int          MEMI_ADDR_WIDTH = 5,
    parameter int          MEMI_DATA_WIDTH = 32,
    parameter int          RD_WAIT_CYCLES  = 1,
    parameter int          NR_BP           = 2,
    parameter logic [31:0] DBG_ID          = 32'h0DC0_0001
) (
    input  logic                       memi_clk,
    input  logic                       memi_rst_n,
    input  logic [MEMI_ADDR_WIDTH-1:0] memi_addr,
    input  logic                       memi_sel,
    input  logic                       memi_wr_rd,
    input  logic [MEMI_DATA_WIDTH-1:0] memi_wdata,
    output logic [MEMI_DATA_WIDTH-1:0] memi_rdata,
    output logic                       memi_ready,
    output logic                       core_halt_req,
    output logic                       core_resume_req,
    input  logic                       core_halted,
    output logic [NR_BP*32-1:0]        bp_addr,
    output logic [NR_BP-1:0]           bp_en
);
    typedef enum logic [1:0] {A_IDLE, A_WAIT, A_RESP, A_DONE} acc_t;
    typedef enum logic [1:0] {H_RUNNING, H_HALTING, H_HALTED, H_RESUMING} hs_t;

    acc_t                       acc;
    hs_t                        hs;
    logic [MEMI_ADDR_WIDTH-1:0] a_addr;
    logic                       a_wr;
    logic [MEMI_DATA_WIDTH-1:0] a_wdata;
    logic [2:0]                 wait_cnt;
    logic [31:0]                dtr;
    logic                       err;
    logic                       step;

    logic [31:0]      ad;
    logic [31:0]      wd;
    logic [31:0]      rd_val;
    logic [31:0]      bp_rd;
    logic [NR_BP-1:0] bp_sel;
    logic             addr_ok;
    logic             wr_stb;
    logic             ctrl_wr;
    logic             cmd_halt;
    logic             cmd_step;
    logic             cmd_resume;
    logic             cmd_bad;
    logic             err_set;
    logic             err_clr;

    always_comb begin
        ad = 32'(a_addr);
        wd = 32'(a_wdata);
        bp_sel = '0;
        bp_rd = '0;
        for (int i = 0; i < NR_BP; i++)
            if (ad == 32'(8 + i)) begin
                bp_sel[i] = 1'b1;
                bp_rd = bp_addr[32*i +: 32];
            end
        addr_ok = (ad <= 32'd4) || (|bp_sel);
        rd_val = ad == 32'd0 ? DBG_ID :
                 ad == 32'd1 ? 32'd0 :
                 ad == 32'd2 ? {29'd0, err, hs == H_HALTING || hs == H_RESUMING, hs == H_HALTED} :
                 ad == 32'd3 ? dtr :
                 ad == 32'd4 ? 32'(bp_en) :
                 |bp_sel     ? bp_rd : 32'hDEAD_BEEF;
        wr_stb = (acc == A_RESP) && a_wr;
        ctrl_wr = wr_stb && ad == 32'd1;
        // Only one command per CTRL write: HALT beats STEP beats RESUME
        cmd_halt = ctrl_wr && wd[0];
        cmd_step = ctrl_wr && !wd[0] && wd[2];
        cmd_resume = ctrl_wr && !wd[0] && !wd[2] && wd[1];
        cmd_bad = (cmd_halt && hs != H_RUNNING) || ((cmd_step || cmd_resume) && hs != H_HALTED);
        err_set = ((acc == A_RESP) && (!addr_ok || (a_wr && ad == 32'd0))) || cmd_bad;
        err_clr = wr_stb && ad == 32'd2 && wd[2];
    end

    assign memi_ready = acc == A_RESP;
    assign memi_rdata = memi_ready ? MEMI_DATA_WIDTH'(rd_val) : '0;

    always_ff @(posedge memi_clk or negedge memi_rst_n)
        if (!memi_rst_n) begin
            acc <= A_IDLE;
            a_addr <= '0;
            a_wr <= 1'b0;
            a_wdata <= '0;
            wait_cnt <= '0;
        end else begin
            case (acc)
                A_IDLE: if (memi_sel) begin
                    a_addr <= memi_addr;
                    a_wr <= memi_wr_rd;
                    a_wdata <= memi_wdata;
                    wait_cnt <= '0;
                    acc <= (!memi_wr_rd && RD_WAIT_CYCLES > 0) ? A_WAIT : A_RESP;
                end
                A_WAIT: begin
                    wait_cnt <= wait_cnt + 3'd1;
                    if (wait_cnt == 3'(RD_WAIT_CYCLES - 1)) acc <= A_RESP;
                end
                A_RESP: acc <= A_DONE;
                default: if (!memi_sel) acc <= A_IDLE;
            endcase
        end

    always_ff @(posedge memi_clk or negedge memi_rst_n)
        if (!memi_rst_n) begin
            dtr <= '0;
            bp_en <= '0;
            bp_addr <= '0;
            err <= 1'b0;
        end else begin
            err <= err_set || (err && !err_clr);
            if (wr_stb && ad == 32'd3) dtr <= wd;
            if (wr_stb && ad == 32'd4) bp_en <= wd[NR_BP-1:0];
            for (int i = 0; i < NR_BP; i++)
                if (wr_stb && bp_sel[i]) bp_addr[32*i +: 32] <= wd;
        end

    always_ff @(posedge memi_clk or negedge memi_rst_n)
        if (!memi_rst_n) begin
            hs <= H_RUNNING;
            step <= 1'b0;
            core_halt_req <= 1'b0;
            core_resume_req <= 1'b0;
        end else begin
            case (hs)
                H_RUNNING: if (cmd_halt) begin
                    hs <= H_HALTING;
                    core_halt_req <= 1'b1;
                end
                H_HALTING: if (core_halted) begin
                    hs <= H_HALTED;
                    core_halt_req <= 1'b0;
                end
                H_HALTED: if (cmd_step || cmd_resume) begin
                    hs <= H_RESUMING;
                    step <= cmd_step;
                    core_resume_req <= 1'b1;
                end
                H_RESUMING: if (!core_halted) begin
                    hs <= step ? H_HALTING : H_RUNNING;
                    core_halt_req <= step;
                    core_resume_req <= 1'b0;
                    step <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_core_dbg_regs.sv
// tb_core_dbg_regs: directed scenarios plus randomized traffic against a
// register-level model of the debug register file and handshake.
module tb_core_dbg_regs;
    localparam int RDW = 1;
    localparam int NBP = 2;
    localparam int RUN = 0, HALTING = 1, HALTED = 2, RESUMING = 3;

    logic             memi_clk = 1'b0;
    logic             memi_rst_n = 1'b0;
    logic [4:0]       memi_addr = '0;
    logic             memi_sel = 1'b0;
    logic             memi_wr_rd = 1'b0;
    logic [31:0]      memi_wdata = '0;
    logic [31:0]      memi_rdata;
    logic             memi_ready;
    logic             core_halt_req;
    logic             core_resume_req;
    logic             core_halted = 1'b0;
    logic [NBP*32-1:0] bp_addr;
    logic [NBP-1:0]   bp_en;

    int checks = 0;
    int errors = 0;

    int          m_st;
    bit          m_step;
    bit          m_err;
    logic [31:0] m_dtr;
    logic [31:0] m_bp[NBP];
    logic [NBP-1:0] m_bpen;

    core_dbg_regs #(.MEMI_ADDR_WIDTH(5), .MEMI_DATA_WIDTH(32), .RD_WAIT_CYCLES(RDW),
                    .NR_BP(NBP), .DBG_ID(32'h0DC0_0001)) dut (
        .memi_clk(memi_clk), .memi_rst_n(memi_rst_n), .memi_addr(memi_addr),
        .memi_sel(memi_sel), .memi_wr_rd(memi_wr_rd), .memi_wdata(memi_wdata),
        .memi_rdata(memi_rdata), .memi_ready(memi_ready), .core_halt_req(core_halt_req),
        .core_resume_req(core_resume_req), .core_halted(core_halted),
        .bp_addr(bp_addr), .bp_en(bp_en));

    always #5 memi_clk = ~memi_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic bit m_bad(input int a);
        return !(a <= 4 || (a >= 8 && a < 8 + NBP));
    endfunction

    function automatic logic [31:0] m_rdval(input int a);
        if (a == 0) return 32'h0DC0_0001;
        if (a == 1) return 32'd0;
        if (a == 2) return {29'd0, m_err, m_st == HALTING || m_st == RESUMING, m_st == HALTED};
        if (a == 3) return m_dtr;
        if (a == 4) return 32'(m_bpen);
        if (a >= 8 && a < 8 + NBP) return m_bp[a-8];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic m_write(input int a, input logic [31:0] d);
        if (m_bad(a) || a == 0) m_err = 1;
        else if (a == 1) begin
            if (d[0]) begin
                if (m_st == RUN) m_st = HALTING; else m_err = 1;
            end else if (d[2] || d[1]) begin
                if (m_st == HALTED) begin m_st = RESUMING; m_step = d[2]; end
                else m_err = 1;
            end
        end else if (a == 2) begin
            if (d[2]) m_err = 0;
        end else if (a == 3) m_dtr = d;
        else if (a == 4) m_bpen = d[NBP-1:0];
        else m_bp[a-8] = d;
    endtask

    task automatic m_settle();
        repeat (2) begin
            if (m_st == HALTING && core_halted) m_st = HALTED;
            else if (m_st == RESUMING && !core_halted) begin
                m_st = m_step ? HALTING : RUN;
                m_step = 0;
            end
        end
    endtask

    task automatic do_reset();
        memi_sel = 0;
        core_halted = 0;
        memi_rst_n = 0;
        repeat (3) @(negedge memi_clk);
        memi_rst_n = 1;
        @(negedge memi_clk);
        m_st = RUN; m_step = 0; m_err = 0; m_dtr = '0; m_bpen = '0;
        for (int i = 0; i < NBP; i++) m_bp[i] = '0;
    endtask

    // One bus access over a fixed 12-cycle window; scrambles the bus after selection.
    task automatic bus(input logic wr, input logic [4:0] addr, input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output int lat, output int np, output int nz,
                       output logic [12:0] hq, output logic [12:0] rq);
        @(negedge memi_clk);
        memi_sel = 1; memi_wr_rd = wr; memi_addr = addr; memi_wdata = wd;
        rd = '0; lat = -1; np = 0; nz = 0; hq = '0; rq = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge memi_clk);
            if (memi_ready) begin np++; lat = c; rd = memi_rdata; end
            else if (memi_rdata !== '0) nz++;
            hq[c] = core_halt_req;
            rq[c] = core_resume_req;
            if (c >= hold) memi_sel = 0;
            memi_addr = 5'($urandom); memi_wdata = $urandom; memi_wr_rd = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        do_reset();
        checks++;
        if ({memi_ready, memi_rdata, core_halt_req, core_resume_req, bp_addr, bp_en} !== '0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b rdata=%h hreq=%b rreq=%b bp_addr=%h bp_en=%b expected all 0",
                     memi_ready, memi_rdata, core_halt_req, core_resume_req, bp_addr, bp_en);
        end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
        bus(0, 5'h03, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_dtr got %h exp 0", rd); end
    endtask

    task automatic test_id_read();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        bus(0, 5'h00, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h0DC0_0001) begin errors++; $display("FAIL id_data got %h exp 0dc00001", rd); end
        checks++;
        if (lat !== 1 + RDW || np !== 1 || nz !== 0) begin
            errors++;
            $display("FAIL id_timing lat=%0d pulses=%0d nonzero=%0d exp lat=%0d pulses=1 nonzero=0", lat, np, nz, 1 + RDW);
        end
    endtask

    task automatic test_dtr();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        bus(1, 5'h03, 32'hA5A5_1234, 2, rd, lat, np, nz, hq, rq);
        checks++;
        if (lat !== 1 || np !== 1) begin
            errors++; $display("FAIL dtr_write_timing lat=%0d pulses=%0d exp lat=1 pulses=1", lat, np);
        end
        bus(0, 5'h03, 0, 10, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'hA5A5_1234 || np !== 1) begin
            errors++; $display("FAIL dtr_readback got %h pulses=%0d exp a5a51234 pulses=1", rd, np);
        end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL dtr_err got status %h exp 0", rd); end
    endtask

    task automatic test_halt_resume();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        bus(1, 5'h01, 32'd1, 2, rd, lat, np, nz, hq, rq);
        checks++;
        if (hq[2:1] !== 2'b10 || hq[12] !== 1'b1) begin
            errors++; $display("FAIL halt_req_rise history=%b exp rise in cycle 2 and hold", hq);
        end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h2) begin errors++; $display("FAIL halting_status got %h exp 2", rd); end
        repeat (5) @(negedge memi_clk);
        core_halted = 1;
        @(negedge memi_clk);
        checks++;
        if (core_halt_req !== 1'b0) begin errors++; $display("FAIL halt_req_drop got %b exp 0", core_halt_req); end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL halted_status got %h exp 1", rd); end
        bus(1, 5'h01, 32'd2, 2, rd, lat, np, nz, hq, rq);
        checks++;
        if (rq[2:1] !== 2'b10 || rq[12] !== 1'b1) begin
            errors++; $display("FAIL resume_req_rise history=%b exp rise in cycle 2 and hold", rq);
        end
        core_halted = 0;
        @(negedge memi_clk);
        checks++;
        if (core_resume_req !== 1'b0) begin errors++; $display("FAIL resume_req_drop got %b exp 0", core_resume_req); end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL running_status got %h exp 0", rd); end
    endtask

    task automatic test_step();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        bus(1, 5'h01, 32'd1, 2, rd, lat, np, nz, hq, rq);
        core_halted = 1;
        repeat (2) @(negedge memi_clk);
        bus(1, 5'h01, 32'd4, 2, rd, lat, np, nz, hq, rq);
        checks++;
        if (rq[2:1] !== 2'b10 || hq !== '0) begin
            errors++; $display("FAIL step_resume_req rreq=%b hreq=%b exp rreq rise in cycle 2, hreq 0", rq, hq);
        end
        core_halted = 0;
        @(negedge memi_clk);
        checks++;
        if ({core_halt_req, core_resume_req} !== 2'b10) begin
            errors++; $display("FAIL step_rehalt hreq/rreq=%b%b exp 10", core_halt_req, core_resume_req);
        end
        core_halted = 1;
        @(negedge memi_clk);
        checks++;
        if ({core_halt_req, core_resume_req} !== 2'b00) begin
            errors++; $display("FAIL step_done hreq/rreq=%b%b exp 00", core_halt_req, core_resume_req);
        end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h1) begin errors++; $display("FAIL step_status got %h exp 1", rd); end
        bus(1, 5'h01, 32'd2, 2, rd, lat, np, nz, hq, rq);
        core_halted = 0;
        repeat (2) @(negedge memi_clk);
    endtask

    task automatic test_errors();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        bus(0, 5'h1F, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bad_read got %h exp deadbeef", rd); end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL err_set got status %h exp 4", rd); end
        bus(1, 5'h01, 32'd2, 2, rd, lat, np, nz, hq, rq);
        checks++;
        if (rq !== '0 || hq !== '0) begin
            errors++; $display("FAIL resume_while_running rreq=%b hreq=%b exp 0", rq, hq);
        end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL err_sticky got status %h exp 4", rd); end
        bus(1, 5'h02, 32'h4, 2, rd, lat, np, nz, hq, rq);
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL err_clear got status %h exp 0", rd); end
        bus(1, 5'h00, 32'h1234, 2, rd, lat, np, nz, hq, rq);
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL id_write_err got status %h exp 4", rd); end
        bus(1, 5'h02, 32'h4, 2, rd, lat, np, nz, hq, rq);
        bus(1, 5'h0A, 32'h55, 2, rd, lat, np, nz, hq, rq);
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h4) begin errors++; $display("FAIL bp_slot_err got status %h exp 4", rd); end
        bus(1, 5'h02, 32'h4, 2, rd, lat, np, nz, hq, rq);
    endtask

    task automatic test_bp();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        bus(1, 5'h09, 32'h0000_8000, 2, rd, lat, np, nz, hq, rq);
        bus(1, 5'h04, 32'h2, 2, rd, lat, np, nz, hq, rq);
        checks++;
        if (bp_addr !== 64'h0000_8000_0000_0000 || bp_en !== 2'b10) begin
            errors++; $display("FAIL bp_outputs bp_addr=%h bp_en=%b exp 0000800000000000 10", bp_addr, bp_en);
        end
        bus(0, 5'h09, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h8000) begin errors++; $display("FAIL bp_readback got %h exp 8000", rd); end
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd; int lat, np, nz; logic [12:0] hq, rq;
        int pulses = 0;
        bus(1, 5'h01, 32'd1, 2, rd, lat, np, nz, hq, rq);
        @(negedge memi_clk);
        memi_sel = 1; memi_wr_rd = 0; memi_addr = 5'h00;
        @(negedge memi_clk);
        memi_rst_n = 0;
        #1;
        memi_sel = 0;
        checks++;
        if ({memi_ready, memi_rdata, core_halt_req, core_resume_req, bp_addr, bp_en} !== '0) begin
            errors++;
            $display("FAIL async_reset ready=%b rdata=%h hreq=%b rreq=%b bp_addr=%h bp_en=%b expected all 0",
                     memi_ready, memi_rdata, core_halt_req, core_resume_req, bp_addr, bp_en);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge memi_clk);
            if (memi_ready) pulses++;
            if (c == 3) memi_rst_n = 1;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL aborted_ready pulses=%0d exp 0", pulses); end
        bus(0, 5'h02, 0, 1, rd, lat, np, nz, hq, rq);
        checks++;
        if (rd !== 32'h0 || np !== 1) begin
            errors++; $display("FAIL after_reset_status got %h pulses=%0d exp 0 pulses=1", rd, np);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp_rd; int lat, np, nz, a, op, exp_lat; logic [12:0] hq, rq;
        logic wr;
        logic [NBP*32-1:0] exp_bp;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 9);
            if (op >= 8) begin
                core_halted = 1'($urandom);
                repeat (2) @(negedge memi_clk);
                m_settle();
            end else begin
                wr = op >= 4;
                a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10));
                d = (a == 1) ? 32'($urandom_range(0, 7)) : $urandom;
                exp_lat = wr ? 1 : 1 + RDW;
                exp_rd = m_rdval(a);
                bus(wr, 5'(a), d, $urandom_range(1, 10), rd, lat, np, nz, hq, rq);
                checks++;
                if (lat !== exp_lat || np !== 1 || nz !== 0) begin
                    errors++;
                    $display("FAIL rnd_timing op=%0d addr=%0d wr=%b lat=%0d pulses=%0d nonzero=%0d exp lat=%0d pulses=1",
                             n, a, wr, lat, np, nz, exp_lat);
                end
                if (!wr) begin
                    checks++;
                    if (rd !== exp_rd) begin
                        errors++; $display("FAIL rnd_read op=%0d addr=%0d got %h exp %h", n, a, rd, exp_rd);
                    end
                    if (m_bad(a)) m_err = 1;
                end else m_write(a, d);
                m_settle();
            end
            for (int i = 0; i < NBP; i++) exp_bp[32*i +: 32] = m_bp[i];
            checks++;
            if ({core_halt_req, core_resume_req} !== {m_st == HALTING, m_st == RESUMING} ||
                bp_en !== m_bpen || bp_addr !== exp_bp) begin
                errors++;
                $display("FAIL rnd_outputs op=%0d hreq/rreq=%b%b bp_en=%b bp_addr=%h exp %b%b %b %h", n,
                         core_halt_req, core_resume_req, bp_en, bp_addr,
                         m_st == HALTING, m_st == RESUMING, m_bpen, exp_bp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_id_read();
        test_dtr();
        test_halt_resume();
        test_step();
        test_errors();
        test_bp();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
